vrf_strb_sequencer: RTL and testbench
=====================================

// Module: vrf_strb_sequencer
// PURPOSE
//  Walks one vector instruction's byte range across VRF beats and emits one byte strobe per beat.
//  Replaces the single-beat first/last mask computation with a sequenced generator.
//  Handles vstart/vl, SEW scaling and v0 masking, with valid/ready flow control.
//  Sits between the operand requester and the VRF write/read port of each lane.
// PARAMETERS
//  DataWidth  128   VRF beat width in bits; StrbW = DataWidth/8 bytes per beat (power of 2, >=64)
//  VLEN       1024  vector register length in bits; max group size (LMUL=8) is VLEN bytes
//  Derived: CntW = $clog2(VLEN)+1 (elements/bytes), BeatW = $clog2(VLEN/StrbW)
// PORTS
//  clk_i        in   1      clock
//  rst_i        in   1      synchronous reset, active-high
//  flush_i      in   1      abort current instruction
//  req_valid_i  in   1      instruction descriptor valid
//  req_ready_o  out  1      sequencer can accept a descriptor
//  vstart_i     in   CntW   first active element
//  vl_i         in   CntW   element count (exclusive end)
//  vsew_i       in   2      0:e8 1:e16 2:e32 3:e64
//  vm_i         in   1      1 = unmasked; 0 = apply v0_bits_i
//  v0_bits_i    in   StrbW  one bit per element of the current beat, LSB = lowest element; used only when vm_i=0
//  out_valid_o  out  1      beat strobe valid
//  out_ready_i  in   1      consumer takes beat
//  beat_idx_o   out  BeatW  beat index within register group
//  strb_o       out  StrbW  byte enables for this beat
//  first_o      out  1      first beat of instruction
//  last_o       out  1      last beat of instruction
//  done_o       out  1      one-cycle pulse: instruction finished
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1; out_valid_o=0; done_o=0; beat_idx_o=0.
//  Accept: req_valid_i & req_ready_o in IDLE latches vm and sew, plus:
//    sb = vstart<<sew and eb = vl<<sew (CntW bits, no overflow for legal inputs).
//  Beats: fb = sb/StrbW, lb = (eb-1)/StrbW.
//  FSM:
//    IDLE -> RUN   when sb < eb.
//    IDLE -> DONE  when sb >= eb (empty instruction). No beats are emitted.
//    RUN: out_valid_o=1, beat_idx_o = current beat counter (starts at fb).
//      - Handshake (out_valid_o & out_ready_i) with beat != lb: counter+1, stay in RUN.
//      - Handshake on lb: -> DONE.
//    DONE: done_o=1 for exactly one cycle, then -> IDLE.
//  req_ready_o=1 only in IDLE. Latency: accept at cycle N gives the first beat valid at cycle N+1.
//  Strobe (combinational from registered state and v0_bits_i):
//    - range = ones, AND ~((1<<(sb%StrbW))-1) when first_o, AND ones>>(StrbW-1-((eb-1)%StrbW)) when last_o.
//    - vm=0: each v0 bit k is replicated 2^sew times onto bytes [k<<sew +: 1<<sew]; bits >= StrbW>>sew are ignored.
//    - strb_o = range & replicated mask.
//  first_o = (beat==fb) and last_o = (beat==lb). Both are high on a single-beat instruction.
//  Backpressure: while out_valid_o & !out_ready_i, beat_idx_o/first_o/last_o stay stable.
//    strb_o changes only if v0_bits_i changes.
//  flush_i (any state): next cycle IDLE, out_valid_o=0, no done_o pulse. flush_i has priority over accept and handshake.
//  rst_i mid-operation: same as flush, and all state returns to reset values.
//  A new descriptor is accepted in the cycle after done_o, at the earliest.
// TESTING (DataWidth=128, VLEN=1024)
//  1. vstart=0 vl=16 e8 vm=1 -> one beat: idx0 strb=FFFF first=last=1; done_o pulses the cycle after the handshake.
//  2. vstart=3 vl=21 e16 -> beats 0,1,2 with strb FFC0, FFFF, 03FF; first on idx0, last on idx2.
//  3. vstart=5 vl=5 -> out_valid_o never set; done_o pulses at accept+1; req_ready_o back at accept+2.
//  4. vl=64 e8 with out_ready_i low 3 cycles on beat 1 -> idx/strb/first/last held; 4 beats total; no loss, no duplicate.
//  5. vstart=0 vl=4 e32 vm=0 v0_bits=0101 -> strb=0F0F; with vm=1 -> FFFF.
//  6. flush_i while on beat 2 of 4 -> out_valid_o=0 next cycle, req_ready_o=1, no done_o; next descriptor runs clean.

Source files
------------

// File: rtl/vrf_strb_sequencer.sv
// ---------------------------------------------------------------------------
// vrf_strb_sequencer
//   Walks the byte range of one vector instruction across VRF beats and emits
//   one byte strobe per beat. Handles vstart/vl, SEW scaling and v0 masking,
//   with valid/ready flow control on both sides.
//
// Ports
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   flush_i      abort the current instruction (no done_o pulse)
//   req_valid_i  descriptor valid
//   req_ready_o  high only in IDLE
//   vstart_i     first active element
//   vl_i         element count (exclusive end)
//   vsew_i       0:e8 1:e16 2:e32 3:e64
//   vm_i         1 = unmasked, 0 = apply v0_bits_i
//   v0_bits_i    one mask bit per element of the current beat
//   out_valid_o  beat strobe valid
//   out_ready_i  consumer takes the beat
//   beat_idx_o   beat index within the register group
//   strb_o       byte enables for this beat
//   first_o      first beat of the instruction
//   last_o       last beat of the instruction
//   done_o       one-cycle pulse when the instruction finishes
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a descriptor, req_ready_o high
// RUN   | presenting beat beat_q, advancing on each handshake
// DONE  | done_o pulse for one cycle, then back to IDLE
// ---------------------------------------------------------------------------
module vrf_strb_sequencer #(
  parameter  int DataWidth = 128,
  parameter  int VLEN      = 1024,
  localparam int StrbW     = DataWidth / 8,
  localparam int CntW      = $clog2(VLEN) + 1,
  localparam int BeatW     = $clog2(VLEN / StrbW)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [CntW-1:0]  vstart_i,
  input  logic [CntW-1:0]  vl_i,
  input  logic [1:0]       vsew_i,
  input  logic             vm_i,
  input  logic [StrbW-1:0] v0_bits_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BeatW-1:0] beat_idx_o,
  output logic [StrbW-1:0] strb_o,
  output logic             first_o,
  output logic             last_o,
  output logic             done_o
);

  localparam int SW = $clog2(StrbW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q;
  logic [CntW-1:0]  sb_q;
  logic [CntW-1:0]  eb_q;
  logic [CntW-1:0]  beat_q;
  logic             vm_q;
  logic [1:0]       sew_q;

  logic [CntW-1:0]  sb_d;
  logic [CntW-1:0]  eb_d;
  logic [CntW-1:0]  eb_m1;
  logic [CntW-1:0]  fb;
  logic [CntW-1:0]  lb;
  logic             run;
  logic             at_first;
  logic             at_last;

  logic [StrbW-1:0] first_mask;
  logic [StrbW-1:0] last_mask;
  logic [StrbW-1:0] range_mask;
  logic [StrbW-1:0] rep_mask;

  assign sb_d  = vstart_i << vsew_i;
  assign eb_d  = vl_i << vsew_i;
  assign eb_m1 = eb_q - CntW'(1);
  assign fb    = sb_q >> SW;
  assign lb    = eb_m1 >> SW;

  assign run      = (state_q == RUN);
  assign at_first = (beat_q == fb);
  assign at_last  = (beat_q == lb);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sb_q    <= '0;
      eb_q    <= '0;
      beat_q  <= '0;
      vm_q    <= 1'b1;
      sew_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            sb_q    <= sb_d;
            eb_q    <= eb_d;
            vm_q    <= vm_i;
            sew_q   <= vsew_i;
            beat_q  <= sb_d >> SW;
            // An empty range skips straight to the done pulse.
            state_q <= (sb_d < eb_d) ? RUN : DONE;
          end
        end
        RUN: begin
          if (out_ready_i) begin
            if (at_last) begin
              state_q <= DONE;
            end else begin
              beat_q <= beat_q + CntW'(1);
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Range mask trims the leading bytes below sb on the first beat and the
  // trailing bytes at/after eb on the last beat; middle beats are full.
  assign first_mask = {StrbW{1'b1}} << sb_q[SW-1:0];
  assign last_mask  = {StrbW{1'b1}} >> (SW'(StrbW - 1) - eb_m1[SW-1:0]);

  always_comb begin
    range_mask = {StrbW{1'b1}};
    if (at_first) range_mask = range_mask & first_mask;
    if (at_last)  range_mask = range_mask & last_mask;
  end

  // Byte j belongs to element j>>sew of this beat, so it takes that v0 bit.
  // v0 bits beyond the beat's element count are never selected.
  always_comb begin
    logic [SW-1:0] src;
    rep_mask = '0;
    src      = '0;
    for (int j = 0; j < StrbW; j++) begin
      src         = SW'(j) >> sew_q;
      rep_mask[j] = v0_bits_i[src];
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign out_valid_o = run;
  assign done_o      = (state_q == DONE);
  assign beat_idx_o  = beat_q[BeatW-1:0];
  assign first_o     = run & at_first;
  assign last_o      = run & at_last;
  assign strb_o      = run ? (range_mask & (vm_q ? {StrbW{1'b1}} : rep_mask)) : '0;

endmodule

// File: tb/tb_vrf_strb_sequencer.sv
module tb_vrf_strb_sequencer;

  localparam int CntW  = 11;
  localparam int BeatW = 6;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [CntW-1:0]  vstart_i;
  logic [CntW-1:0]  vl_i;
  logic [1:0]       vsew_i;
  logic             vm_i;
  logic [15:0]      v0_bits_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [BeatW-1:0] beat_idx_o;
  logic [15:0]      strb_o;
  logic             first_o;
  logic             last_o;
  logic             done_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] fixed_strb [4];

  vrf_strb_sequencer #(.DataWidth(128), .VLEN(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .vstart_i(vstart_i), .vl_i(vl_i), .vsew_i(vsew_i), .vm_i(vm_i),
    .v0_bits_i(v0_bits_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .beat_idx_o(beat_idx_o), .strb_o(strb_o), .first_o(first_o),
    .last_o(last_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: byte at absolute offset a is enabled when sb <= a < eb and,
  // when masked, the v0 bit of the element holding that byte is set.
  function automatic logic [15:0] model_strb(input int sb, input int eb, input int b,
                                             input int sew, input bit vm, input logic [15:0] v0);
    logic [15:0] s;
    s = '0;
    for (int j = 0; j < 16; j++) begin
      int a;
      a = b * 16 + j;
      if (a >= sb && a < eb && (vm || v0[j / (1 << sew)])) s[j] = 1'b1;
    end
    return s;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i); #1; n++;
    end
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++; $display("FAIL %s ready_timeout got=%b want=1", name, req_ready_o);
    end
  endtask

  // Issues one descriptor and follows it beat by beat. Expected beats come
  // from the byte range; v0 is re-randomised every cycle unless fixed.
  task automatic run_instr(input string name, input int vstart, input int vl, input int sew,
                           input bit vm, input int v0_fix, input int stall_pct,
                           input int hold_beat, input int hold_cycles, input int nfixed);
    int sb, eb, fb, lb, b, n, held, beats;
    bit hs;
    sb = vstart << sew;
    eb = vl << sew;
    fb = sb / 16;
    lb = (eb - 1) / 16;
    @(negedge clk_i); #1;
    wait_ready(name);
    req_valid_i = 1'b1; vstart_i = CntW'(vstart); vl_i = CntW'(vl);
    vsew_i = 2'(sew); vm_i = vm;
    @(negedge clk_i);
    req_valid_i = 1'b0; vstart_i = '0; vl_i = '0; vm_i = ~vm;
    if (sb >= eb) begin
      #1;
      total++;
      if (out_valid_o !== 1'b0 || done_o !== 1'b1) begin
        bad++; $display("FAIL %s empty_accept1 valid=%b done=%b want valid=0 done=1", name, out_valid_o, done_o);
      end
      @(negedge clk_i); #1;
      total++;
      if (done_o !== 1'b0 || req_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
        bad++; $display("FAIL %s empty_accept2 done=%b ready=%b valid=%b want 0/1/0", name, done_o, req_ready_o, out_valid_o);
      end
      return;
    end
    b = fb; n = 0; held = 0; beats = 0;
    forever begin
      v0_bits_i = (v0_fix >= 0) ? 16'(v0_fix) : 16'($urandom);
      if (b == hold_beat && held < hold_cycles) begin
        out_ready_i = 1'b0; held++;
      end else begin
        out_ready_i = ($urandom_range(0, 99) >= stall_pct);
      end
      #1;
      total++;
      if (out_valid_o !== 1'b1 || req_ready_o !== 1'b0 || done_o !== 1'b0) begin
        bad++; $display("FAIL %s run_ctl valid=%b ready=%b done=%b want 1/0/0", name, out_valid_o, req_ready_o, done_o);
      end
      total++;
      if (beat_idx_o !== BeatW'(b) || first_o !== (b == fb) || last_o !== (b == lb)) begin
        bad++; $display("FAIL %s beat idx=%0d first=%b last=%b want idx=%0d first=%b last=%b",
                        name, beat_idx_o, first_o, last_o, b, (b == fb), (b == lb));
      end
      total++;
      if (strb_o !== model_strb(sb, eb, b, sew, vm, v0_bits_i)) begin
        bad++; $display("FAIL %s strb beat=%0d got=%h want=%h", name, b, strb_o, model_strb(sb, eb, b, sew, vm, v0_bits_i));
      end
      if (b - fb < nfixed) begin
        total++;
        if (strb_o !== fixed_strb[b - fb]) begin
          bad++; $display("FAIL %s strb_const beat=%0d got=%h want=%h", name, b, strb_o, fixed_strb[b - fb]);
        end
      end
      hs = out_ready_i;
      n++;
      @(negedge clk_i);
      if (hs) begin
        beats++;
        if (b == lb) break;
        b++;
      end
      if (n > 400) begin
        total++; bad++;
        $display("FAIL %s beat_timeout got=%0d beats want=%0d", name, beats, lb - fb + 1);
        break;
      end
    end
    out_ready_i = 1'b0;
    #1;
    total++;
    if (done_o !== 1'b1 || out_valid_o !== 1'b0 || beats !== lb - fb + 1) begin
      bad++; $display("FAIL %s done_pulse done=%b valid=%b beats=%0d want 1/0/%0d", name, done_o, out_valid_o, beats, lb - fb + 1);
    end
    @(negedge clk_i); #1;
    total++;
    if (done_o !== 1'b0 || req_ready_o !== 1'b1) begin
      bad++; $display("FAIL %s after_done done=%b ready=%b want 0/1", name, done_o, req_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++;
    if (req_ready_o !== 1'b1 || out_valid_o !== 1'b0 || done_o !== 1'b0 || beat_idx_o !== '0) begin
      bad++; $display("FAIL reset ready=%b valid=%b done=%b idx=%0d want 1/0/0/0", req_ready_o, out_valid_o, done_o, beat_idx_o);
    end
  endtask

  task automatic test_single_beat();
    fixed_strb[0] = 16'hFFFF;
    run_instr("single", 0, 16, 0, 1'b1, -1, 0, -1, 0, 1);
  endtask

  task automatic test_e16_range();
    fixed_strb[0] = 16'hFFC0; fixed_strb[1] = 16'hFFFF; fixed_strb[2] = 16'h03FF;
    run_instr("e16_range", 3, 21, 1, 1'b1, -1, 0, -1, 0, 3);
  endtask

  task automatic test_empty();
    run_instr("empty", 5, 5, 0, 1'b1, -1, 0, -1, 0, 0);
    run_instr("empty_gt", 9, 4, 2, 1'b0, -1, 0, -1, 0, 0);
  endtask

  task automatic test_backpressure();
    run_instr("backpressure", 0, 64, 0, 1'b1, -1, 0, 1, 3, 0);
  endtask

  task automatic test_mask();
    fixed_strb[0] = 16'h0F0F;
    run_instr("mask_vm0", 0, 4, 2, 1'b0, 16'h0005, 0, -1, 0, 1);
    fixed_strb[0] = 16'hFFFF;
    run_instr("mask_vm1", 0, 4, 2, 1'b1, 16'h0005, 0, -1, 0, 1);
  endtask

  // Stop a 4-beat instruction on beat 2 with either flush or reset.
  task automatic abort_mid(input string name, input bit use_rst);
    @(negedge clk_i); #1;
    wait_ready(name);
    req_valid_i = 1'b1; vstart_i = '0; vl_i = CntW'(64); vsew_i = 2'd0; vm_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    total++;
    if (out_valid_o !== 1'b1 || beat_idx_o !== BeatW'(2)) begin
      bad++; $display("FAIL %s on_beat2 valid=%b idx=%0d want 1/2", name, out_valid_o, beat_idx_o);
    end
    if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    #1;
    total++;
    if (out_valid_o !== 1'b0 || req_ready_o !== 1'b1 || done_o !== 1'b0) begin
      bad++; $display("FAIL %s abort valid=%b ready=%b done=%b want 0/1/0", name, out_valid_o, req_ready_o, done_o);
    end
    if (use_rst) begin
      total++;
      if (beat_idx_o !== '0) begin
        bad++; $display("FAIL %s rst_idx got=%0d want=0", name, beat_idx_o);
      end
    end
    @(negedge clk_i); #1;
    total++;
    if (done_o !== 1'b0 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL %s abort_later done=%b valid=%b want 0/0", name, done_o, out_valid_o);
    end
    fixed_strb[0] = 16'hFFF0; fixed_strb[1] = 16'h00FF;
    run_instr({name, "_next"}, 2, 12, 1, 1'b1, -1, 30, -1, 0, 2);
  endtask

  task automatic test_flush();
    abort_mid("flush", 1'b0);
  endtask

  task automatic test_mid_reset();
    abort_mid("mid_reset", 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int sew, maxel, vl, vstart;
      sew   = $urandom_range(0, 3);
      maxel = 1024 >> sew;
      vl    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, maxel) : $urandom_range(0, 40);
      vstart = ($urandom_range(0, 7) == 0) ? $urandom_range(vl, maxel) : $urandom_range(0, vl);
      run_instr("random", vstart, vl, sew, 1'($urandom_range(0, 1)), -1, 40, -1, 0, 0);
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; vstart_i = '0; vl_i = '0;
    vsew_i = '0; vm_i = 1'b1; v0_bits_i = '0; out_ready_i = 1'b0;
    test_reset();
    test_single_beat();
    test_e16_range();
    test_empty();
    test_backpressure();
    test_mask();
    test_flush();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
